// File: rtl/mxint_block_quantizer_pkg.sv
// ============================================================================
// Module  : mxint_pkg
// Brief   : Shared types and helpers for the MXINT block quantizer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mxint_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      EMIT = 1'b1
   } state_e;

   // Significant bit length of a sign-extended value: L(x) for x>=0, L(~x) for x<0.
   function automatic int unsigned sig_len(input logic [63:0] x);
      logic [63:0] v;
      int unsigned len;
      v   = x[63] ? ~x : x;
      len = 0;
      for (int i = 0; i < 64; i++) begin
         if (v[i]) len = i + 1;
      end
      return len;
   endfunction

   // Bits needed to hold a shift amount in 0..in_w-man_w.
   function automatic int unsigned min_exp_width(input int unsigned in_w, input int unsigned man_w);
      int unsigned w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'd1 << i) <= (in_w - man_w)) w = i + 1;
      end
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mxint_block_quantizer_if.sv
// ============================================================================
// Module  : mxint_block_quantizer_if
// Brief   : Element-in / mantissa-out handshake bundle of the quantizer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mxint_block_quantizer_if #(
   parameter int IN_WIDTH  = 16,
   parameter int MAN_WIDTH = 8,
   parameter int EXP_WIDTH = 4
) ();
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [MAN_WIDTH-1:0] out_man;
   logic [EXP_WIDTH-1:0] out_exp;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_man, out_exp, out_valid, out_last
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_man, out_exp, out_valid, out_last
   );
endinterface

`default_nettype wire

// File: rtl/mxint_block_quantizer_clamp.sv
// ============================================================================
// Module  : signed_clamp
// Brief   : Saturates a signed IN_W-bit value into OUT_W bits (optionally symmetric).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module signed_clamp #(
   parameter int IN_W      = 17,
   parameter int OUT_W     = 8,
   parameter int SYMMETRIC = 0
) (
   input  logic signed [IN_W-1:0]  in_val,
   output logic signed [OUT_W-1:0] out_val
);

   localparam logic signed [IN_W-1:0] c_max = IN_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [IN_W-1:0] c_min = (SYMMETRIC != 0) ? -c_max : -c_max - IN_W'(1);

   always_comb begin
      out_val = in_val[OUT_W-1:0];
      if (in_val > c_max) begin
         out_val = c_max[OUT_W-1:0];
      end else if (in_val < c_min) begin
         out_val = c_min[OUT_W-1:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/mxint_block_quantizer.sv
// ============================================================================
// Module  : mxint_block_quantizer
// Brief   : Buffers BLOCK_SIZE signed elements, derives a shared exponent and
//           replays them as MAN_WIDTH-bit mantissas. MXINT_ROUND_EN selects
//           round-half-up instead of truncation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mxint_block_quantizer
   import mxint_pkg::*;
#(
   parameter int IN_WIDTH   = 16,
   parameter int MAN_WIDTH  = 8,
   parameter int EXP_WIDTH  = 4,
   parameter int BLOCK_SIZE = 16,
   parameter int SYMMETRIC  = 0
) (
   input  wire logic               clk,
   input  wire logic               rst,
   mxint_block_quantizer_if.slave  bus
);

   localparam int c_cnt_w = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int c_len_w = $clog2(IN_WIDTH + 1);
   localparam int c_sh_w  = min_exp_width(IN_WIDTH, MAN_WIDTH);
   localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(BLOCK_SIZE - 1);
   localparam logic [c_len_w-1:0] c_man_len  = c_len_w'(MAN_WIDTH - 1);

   state_e                     state_q, state_d;
   logic [c_cnt_w-1:0]         cnt_q, cnt_d;
   logic [c_len_w-1:0]         max_len_q, max_len_d;
   logic [c_sh_w-1:0]          shift_q, shift_d;
   logic [IN_WIDTH-1:0]        buf_q [BLOCK_SIZE];
   logic [IN_WIDTH-1:0]        buf_d [BLOCK_SIZE];
   logic                       in_ready_q, in_ready_d;
   logic                       out_valid_q, out_valid_d;
   logic                       out_last_q, out_last_d;
   logic [MAN_WIDTH-1:0]       out_man_q, out_man_d;

   logic [c_len_w-1:0]         in_len;
   logic [c_len_w-1:0]         max_len_new;
   logic [c_sh_w-1:0]          shift_new;
   logic [c_cnt_w-1:0]         sel_idx;
   logic [c_sh_w-1:0]          sel_shift;
   logic signed [IN_WIDTH:0]   sel_ext;
   logic signed [IN_WIDTH:0]   bias;
   logic signed [IN_WIDTH:0]   shifted;
   logic signed [MAN_WIDTH-1:0] clamped;

   // Running max_len including the element currently offered, and its shift.
   always_comb begin
      in_len      = c_len_w'(sig_len({{(64 - IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data}));
      max_len_new = (in_len > max_len_q) ? in_len : max_len_q;
      shift_new   = '0;
      if (max_len_new > c_man_len) begin
         shift_new = c_sh_w'(max_len_new - c_man_len);
      end
   end

   // The block's first element is loaded with the shift derived on the final accept.
   always_comb begin
      sel_idx   = (state_q == FILL) ? '0 : cnt_q + c_cnt_w'(1);
      sel_shift = (state_q == FILL) ? shift_new : shift_q;
      sel_ext   = {buf_q[sel_idx][IN_WIDTH-1], buf_q[sel_idx]};
      bias      = '0;
`ifdef MXINT_ROUND_EN
      if (sel_shift != '0) begin
         bias = (IN_WIDTH + 1)'(1) << (sel_shift - c_sh_w'(1));
      end
`endif
      shifted = (sel_ext + bias) >>> sel_shift;
   end

   signed_clamp #(
      .IN_W      (IN_WIDTH + 1),
      .OUT_W     (MAN_WIDTH),
      .SYMMETRIC (SYMMETRIC)
   ) u_clamp (
      .in_val  (shifted),
      .out_val (clamped)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      max_len_d   = max_len_q;
      shift_d     = shift_q;
      buf_d       = buf_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_man_d   = out_man_q;

      case (state_q)
         FILL: begin
            if (bus.in_valid && in_ready_q) begin
               buf_d[cnt_q] = bus.in_data;
               max_len_d    = max_len_new;
               if (cnt_q == c_last_idx) begin
                  cnt_d       = '0;
                  shift_d     = shift_new;
                  state_d     = EMIT;
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b0;
                  out_man_d   = clamped;
               end else begin
                  cnt_d = cnt_q + c_cnt_w'(1);
               end
            end
         end
         EMIT: begin
            if (out_valid_q && bus.out_ready) begin
               if (cnt_q == c_last_idx) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  cnt_d       = '0;
                  max_len_d   = '0;
                  state_d     = FILL;
               end else begin
                  cnt_d      = cnt_q + c_cnt_w'(1);
                  out_last_d = ((cnt_q + c_cnt_w'(1)) == c_last_idx);
                  out_man_d  = clamped;
               end
            end
         end
         default: state_d = FILL;
      endcase

      in_ready_d = (state_d == FILL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         max_len_q   <= '0;
         shift_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_man_q   <= '0;
         for (int i = 0; i < BLOCK_SIZE; i++) buf_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         max_len_q   <= max_len_d;
         shift_q     <= shift_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_man_q   <= out_man_d;
         buf_q       <= buf_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_man   = out_man_q;
   assign bus.out_exp   = EXP_WIDTH'(shift_q);

endmodule

`default_nettype wire

// File: doc/mxint_block_quantizer.md
Name: mxint_block_quantizer

Overview:
- Converts a stream of signed fixed-point values into MXINT blocks: BLOCK_SIZE elements share one exponent and each element gets a MAN_WIDTH-bit signed mantissa.
- The block buffers a full block and tracks the largest significant bit-length while filling.
- It then replays the buffer through a shift stage and a signed_clamp instance, emitting one mantissa per handshake.
- Sits between the accumulator output and the MXINT writeback path.

Parameters:
- IN_WIDTH, 16: signed input element width.
- MAN_WIDTH, 8: output mantissa width; must be < IN_WIDTH.
- EXP_WIDTH, 4: shared exponent width; must hold IN_WIDTH-MAN_WIDTH.
- BLOCK_SIZE, 16: elements per block; >= 2.
- SYMMETRIC, 0: passed to the signed_clamp instance; 1 gives mantissa range [-(2^(MAN_WIDTH-1)-1), 2^(MAN_WIDTH-1)-1].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  IN_WIDTH  signed element.
- in_valid  in  1  element valid.
- in_ready  out  1  block accepts the element.
- out_man  out  MAN_WIDTH  signed mantissa.
- out_exp  out  EXP_WIDTH  shared exponent (right-shift amount), constant across a block.
- out_valid  out  1  mantissa valid.
- out_ready  in  1  consumer accepts the mantissa.
- out_last  out  1  high with the final mantissa of a block.

Behaviour:
- Reset is asynchronous and active-high on rst; everything is clocked on clk. While rst is high:
  - FSM = FILL; element and buffer counters = 0; max_len = 0.
  - in_ready=0, out_valid=0, out_last=0, out_man=0, out_exp=0.
  - in_ready rises the first cycle after rst deasserts.
- FSM states: FILL and EMIT.
- FILL:
  - in_ready=1 and out_valid=0.
  - Each in_valid&&in_ready stores in_data at buf[cnt], increments cnt, and updates max_len.
  - L(x) = bit length of x if x>=0, else bit length of ~x. Examples: L(0)=0, L(-1)=0, L(127)=7, L(-128)=7.
  - max_len = max(max_len, L(in_data)).
  - On the accept with cnt==BLOCK_SIZE-1:
    - shift = max(0, max_len' - (MAN_WIDTH-1)), where max_len' includes the current element.
    - Latch shift into out_exp, clear cnt, go to EMIT.
- EMIT:
  - in_ready=0.
  - Output registers load buf[cnt] processed as follows:
    - Arithmetic right shift by shift.
    - Optional rounding (see Optional Feature).
    - signed_clamp from IN_WIDTH+1 bits to MAN_WIDTH.
  - out_valid rises the cycle after the final input accept. Latency from the last input accept to the first out_valid is 1 cycle.
  - On out_valid&&out_ready the next element is presented in the same register the following cycle, giving 1 mantissa per cycle under continuous ready.
  - out_last=1 when cnt==BLOCK_SIZE-1.
  - On the out_last handshake:
    - out_valid drops.
    - cnt and max_len clear.
    - FSM returns to FILL; in_ready=1 the next cycle.
- Backpressure: while out_valid && !out_ready, out_man, out_exp and out_last hold stable. No skipping or duplication.
- No overlap: a new block is never accepted during EMIT, so throughput is BLOCK_SIZE in + BLOCK_SIZE out cycles per block.
- in_valid during EMIT is ignored because in_ready=0.
- Clamp: without rounding the clamp never saturates by construction. It is still required for SYMMETRIC=1 (where -2^(MAN_WIDTH-1) maps to the minimum symmetric value) and for rounding overflow.
- out_exp is unsigned and lies in 0..IN_WIDTH-MAN_WIDTH.
- rst asserted mid-FILL or mid-EMIT discards the partial block. No output is produced for it.

Optional Feature:
- MXINT_ROUND_EN defined: round-half-up. Add 2^(shift-1) in IN_WIDTH+1 bits before the arithmetic shift when shift>0, then clamp. This can reach 2^(MAN_WIDTH-1), which clamps to MAX.
- Undefined: truncate (floor) by plain arithmetic shift. The adder is absent.

Decomposition:
- Shared package mxint_pkg holds:
  - the state enum (FILL, EMIT);
  - a function computing L(x);
  - a constant function for the minimum EXP_WIDTH.
- One sub-module: the existing signed_clamp (IN_WIDTH+1 -> MAN_WIDTH, SYMMETRIC passed through).
- The buffer is a register array inside this module.

Test Plan (IN_WIDTH=16, MAN_WIDTH=8, BLOCK_SIZE=4, SYMMETRIC=0):
- {100,-50,3,0}, out_ready=1 -> out_exp=0; mantissas 100,-50,3,0; out_last on the 4th; first out_valid 1 cycle after the 4th accept.
- {1000,-1000,5,-5}, truncate -> exp=3; mantissas 125,-125,0,-1. With MXINT_ROUND_EN -> 125,-125,1,-1.
- {1020,0,0,0} with MXINT_ROUND_EN -> exp=3; 1024>>>3=128 clamps to 127. Truncate gives 127. With SYMMETRIC=1, {-128,0,0,0} -> exp=0; mantissa -127.
- {-32768,1,-1,0} -> exp=8; mantissas -128,0,-1,0.
- out_ready toggling 1/0 every cycle plus in_valid held high during EMIT -> outputs stable while stalled, in_ready=0, no extra accepts; the next block starts only after the out_last handshake.
- rst pulsed after 2 inputs, then a full block {8,8,8,8} -> only exp=0 mantissas 8,8,8,8 appear; no stale data.
